// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared definitions for the RTC multiplexed-bus sequencer: state encoding,
// default phase length and the RTC register map used by the control side.
package rtc_bus_sequencer_pkg;

    localparam int RTC_PHASE_CYC_DEF = 10;
    localparam int RTC_BUS_W         = 8;

    localparam logic [RTC_BUS_W-1:0] RTC_ADDR_SEC   = 8'h21;
    localparam logic [RTC_BUS_W-1:0] RTC_ADDR_MIN   = 8'h22;
    localparam logic [RTC_BUS_W-1:0] RTC_ADDR_HOUR  = 8'h23;
    localparam logic [RTC_BUS_W-1:0] RTC_ADDR_DAY   = 8'h24;
    localparam logic [RTC_BUS_W-1:0] RTC_ADDR_MONTH = 8'h25;
    localparam logic [RTC_BUS_W-1:0] RTC_ADDR_YEAR  = 8'h26;
    localparam logic [RTC_BUS_W-1:0] RTC_ADDR_CTRL  = 8'h27;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ADDR_SETUP  = 3'd1,
        ST_ADDR_STROBE = 3'd2,
        ST_ADDR_HOLD   = 3'd3,
        ST_DATA_SETUP  = 3'd4,
        ST_DATA_STROBE = 3'd5,
        ST_DATA_HOLD   = 3'd6,
        ST_DONE        = 3'd7
    } seq_state_e;

    // Successor of a timed bus phase; IDLE and DONE are handled by the FSM itself.
    function automatic seq_state_e next_phase(input seq_state_e s);
        case (s)
            ST_ADDR_SETUP:  return ST_ADDR_STROBE;
            ST_ADDR_STROBE: return ST_ADDR_HOLD;
            ST_ADDR_HOLD:   return ST_DATA_SETUP;
            ST_DATA_SETUP:  return ST_DATA_STROBE;
            ST_DATA_STROBE: return ST_DATA_HOLD;
            ST_DATA_HOLD:   return ST_DONE;
            default:        return ST_IDLE;
        endcase
    endfunction

    function automatic logic is_timed(input seq_state_e s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Control-side request/response and RTC pad signals of the bus sequencer.
// slave = sequencer view, master = controller/pad view.
interface rtc_bus_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              cs_n;
    logic              a_d;
    logic              wr_n;
    logic              rd_n;
    logic [DATA_W-1:0] ad_out;
    logic              ad_oe;
    logic [DATA_W-1:0] ad_in;

    modport slave (
        input  req, rw, addr, wdata, ad_in,
        output busy, done, rdata, cs_n, a_d, wr_n, rd_n, ad_out, ad_oe
    );

    modport master (
        output req, rw, addr, wdata, ad_in,
        input  busy, done, rdata, cs_n, a_d, wr_n, rd_n, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bus_sequencer_phase_timer.sv
// Phase timer: restarts at 0 on start, expire high on the last cycle of a phase.
// Counter saturates at the last count so it idles quietly between transactions.
module rtc_bus_sequencer_phase_timer #(
    parameter int PHASE_CYC = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic expire
);
    localparam int               CNT_W = $clog2(PHASE_CYC + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PHASE_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == LAST);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Runs one read/write cycle on the RTC muxed AD bus per accepted req; 6*PHASE_CYC+1 cycles to done.
// No backpressure queue: req is only sampled in IDLE, requests while busy are dropped.
module rtc_bus_sequencer
    import rtc_bus_sequencer_pkg::*;
#(
    parameter int PHASE_CYC = RTC_PHASE_CYC_DEF,
    parameter int ADDR_W    = RTC_BUS_W,
    parameter int DATA_W    = RTC_BUS_W
) (
    input  logic                clk,
    input  logic                reset,
    rtc_bus_sequencer_if.slave  bus
);
    seq_state_e        state_q, state_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cs_n_q, cs_n_d;
    logic              a_d_q, a_d_d;
    logic              wr_n_q, wr_n_d;
    logic              rd_n_q, rd_n_d;
    logic [DATA_W-1:0] ad_out_q, ad_out_d;
    logic              ad_oe_q, ad_oe_d;
    logic              phase_start;
    logic              phase_expire;

    rtc_bus_sequencer_phase_timer #(.PHASE_CYC(PHASE_CYC)) u_phase_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (phase_start),
        .expire (phase_expire)
    );

    assign phase_start = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    state_d = ST_ADDR_SETUP;
                    rw_d    = bus.rw;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                if (phase_expire) begin
                    state_d = next_phase(state_q);
                end
            end
        endcase

        if ((state_q == ST_DATA_STROBE) && phase_expire && rw_q) begin
            rdata_d = bus.ad_in;
        end

        // Pins are decoded from the state being entered so the registered outputs line up with it.
        busy_d   = is_timed(state_d);
        done_d   = (state_d == ST_DONE);
        cs_n_d   = 1'b1;
        a_d_d    = 1'b1;
        wr_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = '0;

        case (state_d)
            ST_ADDR_SETUP, ST_ADDR_STROBE, ST_ADDR_HOLD: begin
                cs_n_d   = 1'b0;
                a_d_d    = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = DATA_W'(addr_d);
                if (state_d == ST_ADDR_STROBE) begin
                    wr_n_d = 1'b0;
                end
            end
            ST_DATA_SETUP, ST_DATA_STROBE, ST_DATA_HOLD: begin
                cs_n_d = 1'b0;
                if (!rw_d) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end
                if (state_d == ST_DATA_STROBE) begin
                    if (rw_d) begin
                        rd_n_d = 1'b0;
                    end else begin
                        wr_n_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            a_d_q    <= 1'b1;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cs_n_q   <= cs_n_d;
            a_d_q    <= a_d_d;
            wr_n_q   <= wr_n_d;
            rd_n_q   <= rd_n_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.rdata  = rdata_q;
    assign bus.cs_n   = cs_n_q;
    assign bus.a_d    = a_d_q;
    assign bus.wr_n   = wr_n_q;
    assign bus.rd_n   = rd_n_q;
    assign bus.ad_out = ad_out_q;
    assign bus.ad_oe  = ad_oe_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer with PHASE_CYC=2 and a simple RTC pad model.
module tb_rtc_bus_sequencer;
    import rtc_bus_sequencer_pkg::*;

    logic       clk;
    logic       reset;
    logic [7:0] rd_val;
    int         checks;
    int         errors;
    logic       done_prev;

    // per-transaction observations, filled by observe()
    int   cs_lo, cs_falls, fall2_cyc, addr_drv, data_drv, wr_addr, wr_data;
    int   rd_lo, oe_data, busy_cnt, done_cnt, done_cyc, done2_cyc;
    logic [7:0] rdata_done;

    rtc_bus_sequencer_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    rtc_bus_sequencer #(.PHASE_CYC(2), .ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RTC drives the pad only while rd_n is low; otherwise a distinct idle pattern.
    assign bus.ad_in = (bus.rd_n === 1'b0) ? rd_val : 8'hA5;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks += 3;
            assert (!(bus.rd_n === 1'b0 && bus.wr_n === 1'b0)) else begin
                errors++;
                $error("FAIL strobe_overlap: rd_n=%b wr_n=%b, both low not allowed", bus.rd_n, bus.wr_n);
            end
            assert (!(bus.rd_n === 1'b0 && bus.ad_oe === 1'b1)) else begin
                errors++;
                $error("FAIL oe_during_read: ad_oe=%b with rd_n=%b, expected ad_oe=0", bus.ad_oe, bus.rd_n);
            end
            assert (!(bus.done === 1'b1 && done_prev === 1'b1)) else begin
                errors++;
                $error("FAIL done_width: done high %0d consecutive cycles, expected 1", 2);
            end
            done_prev = bus.done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic start_txn(input logic r, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.rw    = r;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
    endtask

    // Cycle k=1 is the cycle right after the accept edge.
    task automatic observe(input int ncyc, input int drop_cyc, input int inj_cyc,
                           input logic [7:0] exp_addr, input logic [7:0] exp_wdata);
        logic prev_cs;
        prev_cs = 1'b1;
        cs_lo = 0; cs_falls = 0; fall2_cyc = 0; addr_drv = 0; data_drv = 0;
        wr_addr = 0; wr_data = 0; rd_lo = 0; oe_data = 0; busy_cnt = 0;
        done_cnt = 0; done_cyc = 0; done2_cyc = 0; rdata_done = 8'h00;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (bus.cs_n === 1'b0) cs_lo++;
            if (prev_cs === 1'b1 && bus.cs_n === 1'b0) begin
                cs_falls++;
                if (cs_falls == 2) fall2_cyc = k;
            end
            prev_cs = bus.cs_n;
            if (!bus.cs_n && !bus.a_d && bus.ad_oe && bus.ad_out == exp_addr) addr_drv++;
            if (!bus.cs_n && bus.a_d && bus.ad_oe && bus.ad_out == exp_wdata) data_drv++;
            if (!bus.wr_n && !bus.a_d) wr_addr++;
            if (!bus.wr_n && bus.a_d) wr_data++;
            if (!bus.rd_n) rd_lo++;
            if (!bus.cs_n && bus.a_d && bus.ad_oe) oe_data++;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc   = k;
                    rdata_done = bus.rdata;
                end else begin
                    done2_cyc = k;
                end
            end
            if (k == drop_cyc) bus.req = 1'b0;
            if (k == inj_cyc) begin
                bus.req   = 1'b1;
                bus.rw    = 1'b0;
                bus.addr  = RTC_ADDR_HOUR;
                bus.wdata = 8'hEE;
            end
            if (k == inj_cyc + 1) bus.req = 1'b0;
        end
    endtask

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        done_prev = 1'b0;
        rd_val    = 8'h00;
        reset     = 1'b0;
        bus.req   = 1'b0;
        bus.rw    = 1'b0;
        bus.addr  = 8'h00;
        bus.wdata = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n",   bus.cs_n,   1);
        chk("rst_wr_n",   bus.wr_n,   1);
        chk("rst_rd_n",   bus.rd_n,   1);
        chk("rst_a_d",    bus.a_d,    1);
        chk("rst_ad_out", bus.ad_out, 0);
        chk("rst_ad_oe",  bus.ad_oe,  0);
        chk("rst_busy",   bus.busy,   0);
        chk("rst_done",   bus.done,   0);
        chk("rst_rdata",  bus.rdata,  0);
        reset = 1'b1;

        // write 0x59 to 0x21
        start_txn(1'b0, RTC_ADDR_SEC, 8'h59);
        observe(16, 1, -1, RTC_ADDR_SEC, 8'h59);
        chk("wr_cs_lo",     cs_lo,      12);
        chk("wr_cs_falls",  cs_falls,   1);
        chk("wr_addr_drv",  addr_drv,   6);
        chk("wr_strb_addr", wr_addr,    2);
        chk("wr_strb_data", wr_data,    2);
        chk("wr_data_drv",  data_drv,   6);
        chk("wr_rd_lo",     rd_lo,      0);
        chk("wr_busy",      busy_cnt,   12);
        chk("wr_done_cnt",  done_cnt,   1);
        chk("wr_done_cyc",  done_cyc,   13);
        chk("wr_rdata",     rdata_done, 8'h00);

        // read 0x22, pad returns 0x37
        rd_val = 8'h37;
        start_txn(1'b1, RTC_ADDR_MIN, 8'h00);
        observe(16, 1, -1, RTC_ADDR_MIN, 8'h00);
        chk("rd_cs_lo",     cs_lo,      12);
        chk("rd_addr_drv",  addr_drv,   6);
        chk("rd_strb_addr", wr_addr,    2);
        chk("rd_wr_data",   wr_data,    0);
        chk("rd_oe_data",   oe_data,    0);
        chk("rd_rd_lo",     rd_lo,      2);
        chk("rd_done_cyc",  done_cyc,   13);
        chk("rd_rdata",     rdata_done, 8'h37);

        // write request injected mid-read is dropped
        rd_val = 8'h4C;
        start_txn(1'b1, RTC_ADDR_DAY, 8'h00);
        observe(30, 1, 5, RTC_ADDR_DAY, 8'h00);
        chk("ign_done_cnt", done_cnt,   1);
        chk("ign_done_cyc", done_cyc,   13);
        chk("ign_cs_falls", cs_falls,   1);
        chk("ign_cs_lo",    cs_lo,      12);
        chk("ign_wr_data",  wr_data,    0);
        chk("ign_rdata",    rdata_done, 8'h4C);

        // req held high across two writes
        start_txn(1'b0, RTC_ADDR_MONTH, 8'h6A);
        observe(32, 27, -1, RTC_ADDR_MONTH, 8'h6A);
        chk("b2b_done_cnt", done_cnt,  2);
        chk("b2b_done1",    done_cyc,  13);
        chk("b2b_done2",    done2_cyc, 27);
        chk("b2b_cs_falls", cs_falls,  2);
        chk("b2b_fall2",    fall2_cyc, 15);
        chk("b2b_cs_lo",    cs_lo,     24);
        chk("b2b_data_drv", data_drv,  12);
        chk("b2b_rdata",    bus.rdata, 8'h4C);

        // reset during DATA_STROBE of a write
        start_txn(1'b0, RTC_ADDR_CTRL, 8'h88);
        @(negedge clk);
        bus.req = 1'b0;
        repeat (7) @(negedge clk);
        @(negedge clk);
        chk("abt_wr_n_pre", bus.wr_n, 0);
        chk("abt_a_d_pre",  bus.a_d,  1);
        reset = 1'b0;
        @(negedge clk);
        chk("abt_cs_n",  bus.cs_n,  1);
        chk("abt_wr_n",  bus.wr_n,  1);
        chk("abt_ad_oe", bus.ad_oe, 0);
        chk("abt_busy",  bus.busy,  0);
        chk("abt_done",  bus.done,  0);
        chk("abt_rdata", bus.rdata, 0);
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done || !bus.cs_n) n++;
        end
        chk("abt_quiet", n, 0);

        rd_val = 8'h91;
        start_txn(1'b1, RTC_ADDR_YEAR, 8'h00);
        observe(16, 1, -1, RTC_ADDR_YEAR, 8'h00);
        chk("post_done_cyc", done_cyc,   13);
        chk("post_done_cnt", done_cnt,   1);
        chk("post_rd_lo",    rd_lo,      2);
        chk("post_rdata",    rdata_done, 8'h91);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
